// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, port-source encoding and helpers for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;
  localparam int RF_ADDR_SIZE = 5;
  localparam int DATA_SIZE    = 32;
  localparam int PC_SIZE      = 32;
  localparam int DROP_CNT_W   = 16;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_WB,
    PORT_LU,
    PORT_LU_SKIP
  } port_src_e;

  function automatic logic [DROP_CNT_W-1:0] sat_inc16(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction
endpackage

// File: rtl/rf_wport_arbiter_if.sv
// WB / LU / ID / regfile-port signal bundle around the write-port arbiter.
interface rf_wport_arbiter_if
  import rf_wport_arbiter_pkg::*;
#(
  parameter int AW = RF_ADDR_SIZE,
  parameter int DW = DATA_SIZE
);
  logic                  wb_rf_we;
  logic [AW-1:0]         wb_rf_waddr;
  logic [DW-1:0]         wb_rf_wdata;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [AW-1:0]         lu_waddr;
  logic [DW-1:0]         lu_wdata;
  logic [PC_SIZE-1:0]    lu_pc;
  logic [AW-1:0]         id_rj;
  logic [AW-1:0]         id_rk;
  logic                  id_pend_hit;
  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [DW-1:0]         rf_wdata;
  logic                  rf_src_lu;
  logic [PC_SIZE-1:0]    lu_debug_pc;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output wb_rf_we, wb_rf_waddr, wb_rf_wdata,
    output lu_valid, lu_waddr, lu_wdata, lu_pc,
    output id_rj, id_rk,
    input  lu_ready, id_pend_hit,
    input  rf_we, rf_waddr, rf_wdata, rf_src_lu, lu_debug_pc, drop_cnt
  );

  modport slave (
    input  wb_rf_we, wb_rf_waddr, wb_rf_wdata,
    input  lu_valid, lu_waddr, lu_wdata, lu_pc,
    input  id_rj, id_rk,
    output lu_ready, id_pend_hit,
    output rf_we, rf_waddr, rf_wdata, rf_src_lu, lu_debug_pc, drop_cnt
  );
endinterface

// File: rtl/rf_wport_arbiter_lu_result_fifo.sv
// Small FIFO of LU results with per-entry WAW kill bits and a pending-source compare vector.
module lu_result_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RF_ADDR_SIZE,
  parameter int DW    = DATA_SIZE,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [AW-1:0]      push_waddr,
  input  logic [DW-1:0]      push_wdata,
  input  logic [PC_SIZE-1:0] push_pc,
  input  logic               pop,
  input  logic               kill_en,
  input  logic [AW-1:0]      kill_addr,
  input  logic [AW-1:0]      id_rj,
  input  logic [AW-1:0]      id_rk,
  output logic [CW-1:0]      count,
  output logic [AW-1:0]      head_waddr,
  output logic [DW-1:0]      head_wdata,
  output logic [PC_SIZE-1:0] head_pc,
  output logic               head_kill,
  output logic [DEPTH-1:0]   pend_vec
);
  logic [AW-1:0]      waddr_mem [DEPTH];
  logic [DW-1:0]      wdata_mem [DEPTH];
  logic [PC_SIZE-1:0] pc_mem    [DEPTH];

  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [DEPTH-1:0] kill_reg, kill_next;
  logic [DEPTH-1:0] kill_hit;
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Payload is not reset: validity lives entirely in valid_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_mem[wr_ptr_reg] <= push_waddr;
      wdata_mem[wr_ptr_reg] <= push_wdata;
      pc_mem[wr_ptr_reg]    <= push_pc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign kill_hit[gi] = valid_reg[gi] && (waddr_mem[gi] == kill_addr);
      assign pend_vec[gi] = valid_reg[gi] && !kill_reg[gi] && (waddr_mem[gi] != '0) &&
                            ((waddr_mem[gi] == id_rj) || (waddr_mem[gi] == id_rk));
    end
  endgenerate

  // A slot written this cycle starts clean, so a same-cycle WB match does not kill it.
  always_comb begin
    valid_next = valid_reg;
    kill_next  = kill_reg;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && kill_hit[i])
        kill_next[i] = 1'b1;
      if (pop && (rd_ptr_reg == PW'(i)))
        valid_next[i] = 1'b0;
      if (push && (wr_ptr_reg == PW'(i))) begin
        valid_next[i] = 1'b1;
        kill_next[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg  <= '0;
      kill_reg   <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      kill_reg  <= kill_next;
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  assign count      = count_reg;
  assign head_waddr = waddr_mem[rd_ptr_reg];
  assign head_wdata = wdata_mem[rd_ptr_reg];
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_kill  = kill_reg[rd_ptr_reg];
endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB always wins, LU results queue and drain on idle WB cycles.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RF_ADDR_SIZE,
  parameter int DW    = DATA_SIZE,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  rf_wport_arbiter_if.slave bus
);
  logic [CW-1:0]         count;
  logic [AW-1:0]         head_waddr;
  logic [DW-1:0]         head_wdata;
  logic [PC_SIZE-1:0]    head_pc;
  logic                  head_kill;
  logic [DEPTH-1:0]      pend_vec;
  logic                  lu_fire;
  logic                  pop;
  logic                  kill_en;
  port_src_e             port_src;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  assign bus.lu_ready = (count < CW'(DEPTH));
  assign lu_fire      = bus.lu_valid && bus.lu_ready;
  assign kill_en      = bus.wb_rf_we && (bus.wb_rf_waddr != '0);

  lu_result_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (lu_fire),
    .push_waddr (bus.lu_waddr),
    .push_wdata (bus.lu_wdata),
    .push_pc    (bus.lu_pc),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_addr  (bus.wb_rf_waddr),
    .id_rj      (bus.id_rj),
    .id_rk      (bus.id_rk),
    .count      (count),
    .head_waddr (head_waddr),
    .head_wdata (head_wdata),
    .head_pc    (head_pc),
    .head_kill  (head_kill),
    .pend_vec   (pend_vec)
  );

  // Reset gates the port directly so a live WB request cannot leak through while reset is held.
  always_comb begin
    port_src = PORT_IDLE;
    if (reset)
      port_src = PORT_IDLE;
    else if (bus.wb_rf_we)
      port_src = PORT_WB;
    else if (count != '0)
      port_src = (head_kill || (head_waddr == '0)) ? PORT_LU_SKIP : PORT_LU;
  end

  assign pop = (port_src == PORT_LU) || (port_src == PORT_LU_SKIP);

  always_comb begin
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.rf_src_lu   = 1'b0;
    bus.lu_debug_pc = '0;
    case (port_src)
      PORT_WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_rf_waddr;
        bus.rf_wdata = bus.wb_rf_wdata;
      end
      PORT_LU: begin
        bus.rf_we       = 1'b1;
        bus.rf_waddr    = head_waddr;
        bus.rf_wdata    = head_wdata;
        bus.rf_src_lu   = 1'b1;
        bus.lu_debug_pc = head_pc;
      end
      default: ;
    endcase
  end

  // A drop is counted when the cancelled entry actually leaves the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt_reg <= '0;
    else if (pop && head_kill)
      drop_cnt_reg <= sat_inc16(drop_cnt_reg);
  end

  assign bus.drop_cnt    = drop_cnt_reg;
  assign bus.id_pend_hit = |pend_vec;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter (DEPTH=2).
module tb_rf_wport_arbiter;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   cyc;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wb_rf_we    = 1'b0;
    bus.wb_rf_waddr = '0;
    bus.wb_rf_wdata = '0;
    bus.lu_valid    = 1'b0;
    bus.lu_waddr    = '0;
    bus.lu_wdata    = '0;
    bus.lu_pc       = '0;
    bus.id_rj       = 5'd31;
    bus.id_rk       = 5'd31;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_rf_we    = we;
    bus.wb_rf_waddr = a;
    bus.wb_rf_wdata = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.lu_valid = v;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
    bus.lu_pc    = pc;
  endtask

  task automatic show(input string tag);
    $display("[TB] %s cyc=%0d rf_we=%0b waddr=%0d wdata=%h src_lu=%0b ready=%0b pend=%0b drop=%0d",
             tag, cyc, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src_lu,
             bus.lu_ready, bus.id_pend_hit, bus.drop_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    set_wb(1'b1, 5'd3, 32'hAB);
    #2;
    show("reset");
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_we: got %0b want 0", bus.rf_we); end
    tests_run++; if (bus.rf_waddr !== 5'd0) begin tests_failed++; $display("FAIL reset_rf_waddr: got %0d want 0", bus.rf_waddr); end
    tests_run++; if (bus.rf_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); end
    tests_run++; if (bus.lu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_lu_ready: got %0b want 1", bus.lu_ready); end
    tests_run++; if (bus.id_pend_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_pend: got %0b want 0", bus.id_pend_hit); end
    tests_run++; if (bus.drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
    next_cycle();
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    show("post_reset");
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL idle_rf_we: got %0b want 0", bus.rf_we); end
  endtask

  task automatic test_lu_only();
    next_cycle();
    set_lu(1'b1, 5'd5, 32'h1234, 32'h100);
    bus.id_rj = 5'd5;
    @(negedge clk);
    show("lu_only c0");
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL lu_only_c0_we: got %0b want 0", bus.rf_we); end
    tests_run++; if (bus.id_pend_hit !== 1'b0) begin tests_failed++; $display("FAIL lu_only_c0_pend: got %0b want 0", bus.id_pend_hit); end
    next_cycle();
    set_lu(1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    show("lu_only c1");
    tests_run++; if (bus.rf_we !== 1'b1) begin tests_failed++; $display("FAIL lu_only_we: got %0b want 1", bus.rf_we); end
    tests_run++; if (bus.rf_waddr !== 5'd5) begin tests_failed++; $display("FAIL lu_only_waddr: got %0d want 5", bus.rf_waddr); end
    tests_run++; if (bus.rf_wdata !== 32'h1234) begin tests_failed++; $display("FAIL lu_only_wdata: got %h want 1234", bus.rf_wdata); end
    tests_run++; if (bus.rf_src_lu !== 1'b1) begin tests_failed++; $display("FAIL lu_only_src: got %0b want 1", bus.rf_src_lu); end
    tests_run++; if (bus.lu_debug_pc !== 32'h100) begin tests_failed++; $display("FAIL lu_only_dbg_pc: got %h want 100", bus.lu_debug_pc); end
    tests_run++; if (bus.id_pend_hit !== 1'b1) begin tests_failed++; $display("FAIL lu_only_pend: got %0b want 1", bus.id_pend_hit); end
    next_cycle();
    @(negedge clk);
    show("lu_only c2");
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL lu_only_drained: got %0b want 0", bus.rf_we); end
    tests_run++; if (bus.lu_debug_pc !== 32'h0) begin tests_failed++; $display("FAIL lu_only_dbg_idle: got %h want 0", bus.lu_debug_pc); end
    tests_run++; if (bus.id_pend_hit !== 1'b0) begin tests_failed++; $display("FAIL lu_only_pend_clr: got %0b want 0", bus.id_pend_hit); end
  endtask

  task automatic test_collision();
    next_cycle();
    set_lu(1'b1, 5'd7, 32'h55, 32'h200);
    bus.id_rj = 5'd7;
    @(negedge clk);
    show("collide c0");
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      set_lu(1'b0, 5'd0, 32'h0, 32'h0);
      set_wb(1'b1, 5'd3, 32'hAA);
      @(negedge clk);
      show("collide wb");
      tests_run++; if (bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'hAA || bus.rf_src_lu !== 1'b0)
        begin tests_failed++; $display("FAIL collide_wb_c%0d: got a=%0d d=%h src=%0b want a=3 d=aa src=0", c, bus.rf_waddr, bus.rf_wdata, bus.rf_src_lu); end
      tests_run++; if (bus.id_pend_hit !== 1'b1) begin tests_failed++; $display("FAIL collide_pend_c%0d: got %0b want 1", c, bus.id_pend_hit); end
    end
    next_cycle();
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    show("collide c4");
    tests_run++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h55 || bus.rf_src_lu !== 1'b1)
      begin tests_failed++; $display("FAIL collide_lu: got we=%0b a=%0d d=%h src=%0b want we=1 a=7 d=55 src=1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src_lu); end
    tests_run++; if (bus.id_pend_hit !== 1'b1) begin tests_failed++; $display("FAIL collide_pend_c4: got %0b want 1", bus.id_pend_hit); end
    next_cycle();
    @(negedge clk);
    show("collide c5");
    tests_run++; if (bus.rf_we !== 1'b0 || bus.id_pend_hit !== 1'b0)
      begin tests_failed++; $display("FAIL collide_done: got we=%0b pend=%0b want 0 0", bus.rf_we, bus.id_pend_hit); end
  endtask

  task automatic test_full();
    next_cycle();
    set_wb(1'b1, 5'd1, 32'h11);
    set_lu(1'b1, 5'd10, 32'hA, 32'h300);
    @(negedge clk);
    show("full c0");
    tests_run++; if (bus.lu_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_c0: got %0b want 1", bus.lu_ready); end
    next_cycle();
    set_lu(1'b1, 5'd11, 32'hB, 32'h304);
    @(negedge clk);
    show("full c1");
    tests_run++; if (bus.lu_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_c1: got %0b want 1", bus.lu_ready); end
    next_cycle();
    set_lu(1'b1, 5'd12, 32'hC, 32'h308);
    @(negedge clk);
    show("full c2");
    tests_run++; if (bus.lu_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_c2: got %0b want 0", bus.lu_ready); end
    tests_run++; if (bus.rf_waddr !== 5'd1 || bus.rf_src_lu !== 1'b0) begin tests_failed++; $display("FAIL full_wb_c2: got a=%0d src=%0b want a=1 src=0", bus.rf_waddr, bus.rf_src_lu); end
    next_cycle();
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    show("full c3");
    tests_run++; if (bus.lu_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_c3: got %0b want 0", bus.lu_ready); end
    tests_run++; if (bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hA || bus.lu_debug_pc !== 32'h300)
      begin tests_failed++; $display("FAIL full_pop1: got a=%0d d=%h pc=%h want a=10 d=a pc=300", bus.rf_waddr, bus.rf_wdata, bus.lu_debug_pc); end
    next_cycle();
    @(negedge clk);
    show("full c4");
    tests_run++; if (bus.lu_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_c4: got %0b want 1", bus.lu_ready); end
    tests_run++; if (bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'hB)
      begin tests_failed++; $display("FAIL full_pop2: got a=%0d d=%h want a=11 d=b", bus.rf_waddr, bus.rf_wdata); end
    next_cycle();
    set_lu(1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    show("full c5");
    tests_run++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'hC || bus.lu_debug_pc !== 32'h308)
      begin tests_failed++; $display("FAIL full_pop3: got we=%0b a=%0d d=%h pc=%h want we=1 a=12 d=c pc=308", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.lu_debug_pc); end
    next_cycle();
    @(negedge clk);
    show("full c6");
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL full_drained: got %0b want 0", bus.rf_we); end
  endtask

  task automatic test_waw_cancel();
    next_cycle();
    set_lu(1'b1, 5'd9, 32'h1, 32'h400);
    bus.id_rj = 5'd9;
    @(negedge clk);
    show("waw c0");
    next_cycle();
    set_lu(1'b0, 5'd0, 32'h0, 32'h0);
    set_wb(1'b1, 5'd9, 32'h2);
    @(negedge clk);
    show("waw c1");
    tests_run++; if (bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h2 || bus.rf_src_lu !== 1'b0)
      begin tests_failed++; $display("FAIL waw_wb: got a=%0d d=%h src=%0b want a=9 d=2 src=0", bus.rf_waddr, bus.rf_wdata, bus.rf_src_lu); end
    tests_run++; if (bus.id_pend_hit !== 1'b1) begin tests_failed++; $display("FAIL waw_pend_c1: got %0b want 1", bus.id_pend_hit); end
    next_cycle();
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    show("waw c2");
    tests_run++; if (bus.rf_we !== 1'b0 || bus.rf_src_lu !== 1'b0)
      begin tests_failed++; $display("FAIL waw_no_write: got we=%0b src=%0b want 0 0", bus.rf_we, bus.rf_src_lu); end
    tests_run++; if (bus.id_pend_hit !== 1'b0) begin tests_failed++; $display("FAIL waw_pend_c2: got %0b want 0", bus.id_pend_hit); end
    next_cycle();
    @(negedge clk);
    show("waw c3");
    tests_run++; if (bus.drop_cnt !== 16'd1) begin tests_failed++; $display("FAIL waw_drop: got %0d want 1", bus.drop_cnt); end
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL waw_idle_c3: got %0b want 0", bus.rf_we); end
    // Same-cycle accept and matching WB write: the LU entry must survive.
    next_cycle();
    set_wb(1'b1, 5'd4, 32'h77);
    set_lu(1'b1, 5'd4, 32'h88, 32'h500);
    @(negedge clk);
    show("waw same c0");
    next_cycle();
    set_wb(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    show("waw same c1");
    tests_run++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h88 || bus.rf_src_lu !== 1'b1)
      begin tests_failed++; $display("FAIL waw_same_cycle: got we=%0b a=%0d d=%h src=%0b want we=1 a=4 d=88 src=1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src_lu); end
    tests_run++; if (bus.drop_cnt !== 16'd1) begin tests_failed++; $display("FAIL waw_same_drop: got %0d want 1", bus.drop_cnt); end
  endtask

  task automatic test_r0();
    next_cycle();
    set_lu(1'b1, 5'd0, 32'h99, 32'h600);
    bus.id_rj = 5'd0;
    bus.id_rk = 5'd0;
    @(negedge clk);
    show("r0 c0");
    next_cycle();
    set_lu(1'b1, 5'd6, 32'h66, 32'h604);
    @(negedge clk);
    show("r0 c1");
    tests_run++; if (bus.rf_we !== 1'b0 || bus.rf_src_lu !== 1'b0)
      begin tests_failed++; $display("FAIL r0_no_write: got we=%0b src=%0b want 0 0", bus.rf_we, bus.rf_src_lu); end
    tests_run++; if (bus.id_pend_hit !== 1'b0) begin tests_failed++; $display("FAIL r0_pend: got %0b want 0", bus.id_pend_hit); end
    next_cycle();
    set_lu(1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    show("r0 c2");
    tests_run++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'h66)
      begin tests_failed++; $display("FAIL r0_next: got we=%0b a=%0d d=%h want we=1 a=6 d=66", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    next_cycle();
    @(negedge clk);
    show("r0 c3");
    tests_run++; if (bus.drop_cnt !== 16'd1) begin tests_failed++; $display("FAIL r0_drop: got %0d want 1", bus.drop_cnt); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    drive_idle();
    set_wb(1'b1, 5'd2, 32'h22);
    set_lu(1'b1, 5'd13, 32'hD, 32'h700);
    bus.id_rj = 5'd13;
    @(negedge clk);
    show("areset c0");
    next_cycle();
    set_lu(1'b1, 5'd14, 32'hE, 32'h704);
    @(negedge clk);
    show("areset c1");
    next_cycle();
    set_lu(1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    show("areset c2");
    tests_run++; if (bus.lu_ready !== 1'b0 || bus.id_pend_hit !== 1'b1)
      begin tests_failed++; $display("FAIL areset_queued: got ready=%0b pend=%0b want 0 1", bus.lu_ready, bus.id_pend_hit); end
    reset = 1'b1;
    #1;
    show("areset mid");
    tests_run++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0)
      begin tests_failed++; $display("FAIL areset_port: got we=%0b a=%0d d=%h want 0 0 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tests_run++; if (bus.lu_ready !== 1'b1 || bus.id_pend_hit !== 1'b0)
      begin tests_failed++; $display("FAIL areset_status: got ready=%0b pend=%0b want 1 0", bus.lu_ready, bus.id_pend_hit); end
    tests_run++; if (bus.drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL areset_drop: got %0d want 0", bus.drop_cnt); end
    next_cycle();
    reset = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    show("areset r1");
    tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL areset_after1: got %0b want 0", bus.rf_we); end
    next_cycle();
    @(negedge clk);
    show("areset r2");
    tests_run++; if (bus.rf_we !== 1'b0 || bus.rf_src_lu !== 1'b0)
      begin tests_failed++; $display("FAIL areset_after2: got we=%0b src=%0b want 0 0", bus.rf_we, bus.rf_src_lu); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    test_reset();
    test_lu_only();
    test_collision();
    test_full();
    test_waw_cancel();
    test_r0();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
